// File: rtl/complex_accum_pkg.sv
// Shared definitions for the complex accumulator: the default fractional
// width, the two-state frame controller encoding and the output range check.
package complex_accum_pkg;

   localparam int FRAC_DEF = 5;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   // True when v lies outside the signed range of a w-bit two's-complement value
   function automatic logic out_of_range(input logic signed [63:0] v, input int w);
      logic signed [63:0] lim;
      lim = 64'sd1 <<< (w - 1);
      return (v < -lim) || (v > (lim - 64'sd1));
   endfunction

endpackage

// File: rtl/cplx_reduce.sv
// Reduces one ACC_W accumulator component to OUT_W bits and flags overflow.
// Build option COMPLEX_ACCUM_SAT_EN: saturate to the OUT_W signed limits on
// overflow; otherwise keep the low OUT_W bits (two's-complement wrap).
module cplx_reduce
   import complex_accum_pkg::*;
#(
   parameter int ACC_W = 18,
   parameter int OUT_W = 15
) (
   input  logic signed [ACC_W-1:0] i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_ovf
);

   logic signed [63:0] w_ext;

   assign w_ext = 64'(i_val);
   assign o_ovf = out_of_range(w_ext, OUT_W);

`ifdef COMPLEX_ACCUM_SAT_EN
   // Clamp value chosen by the sign of the unreduced component
   function automatic logic signed [OUT_W-1:0] sat_val(input logic neg);
      return neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   assign o_val = o_ovf ? sat_val(i_val[ACC_W-1]) : i_val[OUT_W-1:0];
`else
   assign o_val = i_val[OUT_W-1:0];
`endif

endmodule

// File: rtl/complex_accum.sv
// Frame accumulator for complex products: sums LEN products (or fewer when
// flushed) and presents the reduced sum on a held valid/ready output.
// Build option COMPLEX_ACCUM_SAT_EN (evaluated in cplx_reduce) selects
// saturation instead of wrap on output overflow.
module complex_accum
   import complex_accum_pkg::*;
#(
   parameter int IN_W  = 15,
   parameter int FRAC  = FRAC_DEF,
   parameter int LEN   = 4,
   parameter int ACC_W = 18,
   parameter int OUT_W = 15,
   localparam int CNT_W = $clog2(LEN + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  preal,
   input  logic signed [IN_W-1:0]  pimag,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] sumreal,
   output logic signed [OUT_W-1:0] sumimag,
   output logic [CNT_W-1:0]        count,
   output logic                    ovf
);

   if ((ACC_W < IN_W + $clog2(LEN)) || (OUT_W > ACC_W) || (LEN < 1) || (FRAC >= IN_W)) begin : g_bad_cfg
      $error("complex_accum: inconsistent width parameters");
   end

   logic [0:0]              r_state;
   logic                    r_out_valid;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [ACC_W-1:0] r_acc_re;
   logic signed [ACC_W-1:0] r_acc_im;
   logic signed [OUT_W-1:0] r_sumreal;
   logic signed [OUT_W-1:0] r_sumimag;
   logic [CNT_W-1:0]        r_count;
   logic                    r_ovf;

   logic                    w_accept;
   logic                    w_close;
   logic [CNT_W-1:0]        w_cnt_next;
   logic signed [ACC_W-1:0] w_next_re;
   logic signed [ACC_W-1:0] w_next_im;
   logic signed [OUT_W-1:0] w_red_re;
   logic signed [OUT_W-1:0] w_red_im;
   logic                    w_ovf_re;
   logic                    w_ovf_im;

   assign in_ready   = (r_state == ST_ACCUM);
   assign w_accept   = in_valid & in_ready;
   assign w_cnt_next = r_cnt + CNT_W'(w_accept);
   assign w_next_re  = r_acc_re + (w_accept ? ACC_W'(preal) : '0);
   assign w_next_im  = r_acc_im + (w_accept ? ACC_W'(pimag) : '0);
   // A flush only closes a frame that holds at least one product, counting
   // a product accepted on the same cycle.
   assign w_close    = in_ready &
                       ((w_accept & (r_cnt == CNT_W'(LEN - 1))) |
                        (flush & ((r_cnt != '0) | w_accept)));

   cplx_reduce #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_red_re (
      .i_val (w_next_re),
      .o_val (w_red_re),
      .o_ovf (w_ovf_re)
   );

   cplx_reduce #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_red_im (
      .i_val (w_next_im),
      .o_val (w_red_im),
      .o_ovf (w_ovf_im)
   );

   // Frame controller: ACCUM until a frame closes, HOLD until the result is taken
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_ACCUM;
         r_out_valid <= 1'b0;
      end else if (r_state == ST_ACCUM) begin
         if (w_close) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
         end
      end else if (out_ready) begin
         r_state     <= ST_ACCUM;
         r_out_valid <= 1'b0;
      end
   end

   // Running sums and product count; both clear on the edge that closes a frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc_re <= '0;
         r_acc_im <= '0;
         r_cnt    <= '0;
      end else if (w_close) begin
         r_acc_re <= '0;
         r_acc_im <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_acc_re <= w_next_re;
         r_acc_im <= w_next_im;
         r_cnt    <= w_cnt_next;
      end
   end

   // Result register, loaded with the reduced closing sum and held until the next close
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sumreal <= '0;
         r_sumimag <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
      end else if (w_close) begin
         r_sumreal <= w_red_re;
         r_sumimag <= w_red_im;
         r_count   <= w_cnt_next;
         r_ovf     <= w_ovf_re | w_ovf_im;
      end
   end

   assign out_valid = r_out_valid;
   assign sumreal   = r_sumreal;
   assign sumimag   = r_sumimag;
   assign count     = r_count;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_complex_accum.sv
// Self-checking bench for complex_accum: directed frames with literal
// expectations, then randomized traffic against a frame-level model.
module tb_complex_accum;

   localparam int IN_W  = 15;
   localparam int LEN   = 4;
   localparam int ACC_W = 18;
   localparam int OUT_W = 15;
   localparam int CNT_W = $clog2(LEN + 1);

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic signed [IN_W-1:0]  preal = '0;
   logic signed [IN_W-1:0]  pimag = '0;
   logic                    flush = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic signed [OUT_W-1:0] sumreal;
   logic signed [OUT_W-1:0] sumimag;
   logic [CNT_W-1:0]        count;
   logic                    ovf;

   int errors = 0;
   int checks = 0;

   complex_accum #(.IN_W(IN_W), .LEN(LEN), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .preal     (preal),
      .pimag     (pimag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sumreal   (sumreal),
      .sumimag   (sumimag),
      .count     (count),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model (frame level) ----------------
   bit m_hold;
   int m_frame_re[$];
   int m_frame_im[$];
   bit m_valid;
   int m_re, m_im, m_cnt;
   bit m_ovf;

   function automatic int reduce(input int s, output bit o);
      int lo, hi, w;
      lo = -(1 << (OUT_W - 1));
      hi = (1 << (OUT_W - 1)) - 1;
      o  = (s < lo) || (s > hi);
`ifdef COMPLEX_ACCUM_SAT_EN
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
`else
      w = s & ((1 << OUT_W) - 1);
      if (w > hi) w = w - (1 << OUT_W);
      return w;
`endif
   endfunction

   always @(negedge reset) begin
      m_hold = 0; m_valid = 0;
      m_frame_re.delete(); m_frame_im.delete();
      m_re = 0; m_im = 0; m_cnt = 0; m_ovf = 0;
   end

   always @(posedge clk) begin
      if (reset) begin
         if (!m_hold) begin
            if (in_valid) begin
               m_frame_re.push_back(int'(preal));
               m_frame_im.push_back(int'(pimag));
            end
            if ((in_valid && m_frame_re.size() == LEN) || (flush && m_frame_re.size() != 0)) begin
               int sr, si;
               bit o1, o2;
               sr = 0; si = 0;
               foreach (m_frame_re[k]) begin
                  sr += m_frame_re[k];
                  si += m_frame_im[k];
               end
               m_re    = reduce(sr, o1);
               m_im    = reduce(si, o2);
               m_ovf   = o1 | o2;
               m_cnt   = m_frame_re.size();
               m_valid = 1;
               m_hold  = 1;
               m_frame_re.delete(); m_frame_im.delete();
            end
         end else if (out_ready) begin
            m_valid = 0;
            m_hold  = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if (in_ready !== !m_hold) begin
            errors++;
            $display("FAIL cmp_in_ready t=%0t actual=%b required=%b", $time, in_ready, !m_hold);
         end
         checks++;
         if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL cmp_out_valid t=%0t actual=%b required=%b", $time, out_valid, m_valid);
         end
         if (m_valid) begin
            checks++;
            if (int'(sumreal) != m_re || int'(sumimag) != m_im || int'(count) != m_cnt || ovf !== m_ovf) begin
               errors++;
               $display("FAIL cmp_result t=%0t actual=%0d,%0d,n%0d,o%b required=%0d,%0d,n%0d,o%b",
                        $time, sumreal, sumimag, count, ovf, m_re, m_im, m_cnt, m_ovf);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; returns at the following falling edge
   task automatic cyc(input bit v, input int re, input int im, input bit fl, input bit ordy);
      in_valid  = v;
      preal     = IN_W'(re);
      pimag     = IN_W'(im);
      flush     = fl;
      out_ready = ordy;
      @(negedge clk);
   endtask

   task automatic frame4(input int re, input int im);
      for (int i = 0; i < 4; i++) cyc(1, re, im, 0, 0);
   endtask

   task automatic release_result();
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sumreal", int'(sumreal), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 39+26j x4
      frame4(1248, 832);
      chk("f1_valid", int'(out_valid), 1);
      chk("f1_re", int'(sumreal), 4992);
      chk("f1_im", int'(sumimag), 3328);
      chk("f1_count", int'(count), 4);
      chk("f1_ovf", int'(ovf), 0);
      release_result();

      // 500+0j x4: overflow
      frame4(16000, 0);
`ifdef COMPLEX_ACCUM_SAT_EN
      chk("f2_re_sat", int'(sumreal), 16383);
`else
      chk("f2_re_wrap", int'(sumreal), -1536);
`endif
      chk("f2_ovf", int'(ovf), 1);
      release_result();

      // -512-512j x4
      frame4(-16384, -16384);
`ifdef COMPLEX_ACCUM_SAT_EN
      chk("f3_re_sat", int'(sumreal), -16384);
      chk("f3_im_sat", int'(sumimag), -16384);
`else
      chk("f3_re_wrap", int'(sumreal), 0);
      chk("f3_im_wrap", int'(sumimag), 0);
`endif
      chk("f3_ovf", int'(ovf), 1);
      release_result();

      // Partial frame closed by flush alone
      cyc(1, 32, 32, 0, 0);
      cyc(1, 32, 32, 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("fl_valid", int'(out_valid), 1);
      chk("fl_re", int'(sumreal), 64);
      chk("fl_im", int'(sumimag), 64);
      chk("fl_count", int'(count), 2);
      release_result();

      // Flush with empty accumulator is ignored
      cyc(0, 0, 0, 1, 0);
      chk("fl_empty_valid", int'(out_valid), 0);
      cyc(0, 0, 0, 0, 0);
      chk("fl_empty_valid2", int'(out_valid), 0);

      // Flush together with the third product
      cyc(1, 32, 32, 0, 0);
      cyc(1, 32, 32, 0, 0);
      cyc(1, 32, 0, 1, 0);
      chk("flacc_re", int'(sumreal), 96);
      chk("flacc_im", int'(sumimag), 64);
      chk("flacc_count", int'(count), 3);
      release_result();

      // Backpressure: result held, products refused
      frame4(1248, 832);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 7, 7, 0, 0);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_re", int'(sumreal), 4992);
      end
      cyc(0, 0, 0, 0, 1);
      chk("bp_drop", int'(out_valid), 0);
      frame4(32, 0);
      chk("bp_next_re", int'(sumreal), 128);
      chk("bp_next_count", int'(count), 4);
      release_result();

      // Asynchronous reset mid-frame
      cyc(1, 32, 0, 0, 0);
      cyc(1, 32, 0, 0, 0);
      in_valid = 1'b0;
      #3 reset = 1'b0;
      #1;
      chk("ar_valid", int'(out_valid), 0);
      chk("ar_re", int'(sumreal), 0);
      chk("ar_count", int'(count), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      frame4(32, 0);
      chk("ar_next_re", int'(sumreal), 128);
      chk("ar_next_count", int'(count), 4);
      release_result();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 9) < 6),
             int'($signed(IN_W'($urandom))),
             int'($signed(IN_W'($urandom))),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 1) == 1));
      end
      cyc(0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/complex_accum.md
Name: complex_accum

Overview:
- Downstream consumer of the complex product stage.
- Accepts a stream of complex products (Q10.5, signed, 15-bit real and imag) over a valid/ready handshake.
- Accumulates LEN products per frame, or fewer on flush, into a wide accumulator.
- Presents the frame sum, reduced to OUT_W bits, on a held valid/ready output with a per-frame overflow flag.

Parameters:
- IN_W, 15: width of preal/pimag (signed, FRAC fractional bits).
- FRAC, 5: fractional bits. Identical for input, accumulator and output; no rescaling.
- LEN, 4: products per frame (>=1).
- ACC_W, 18: accumulator width. Must satisfy ACC_W >= IN_W + clog2(LEN).
- OUT_W, 15: output width (signed, FRAC fractional bits). OUT_W <= ACC_W.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: product available.
- in_ready, output, 1: block can accept a product.
- preal, input, IN_W: product real part.
- pimag, input, IN_W: product imaginary part.
- flush, input, 1: close a partial frame.
- out_valid, output, 1: frame result valid.
- out_ready, input, 1: consumer accepts result.
- sumreal, output, OUT_W: frame sum, real part.
- sumimag, output, OUT_W: frame sum, imaginary part.
- count, output, clog2(LEN+1): number of products in the presented frame.
- ovf, output, 1: sum exceeded OUT_W range in either component.

Behaviour:
- Reset (reset=0, async): state=ACCUM; acc_re=acc_im=0; cnt=0; out_valid=0; sumreal=sumimag=0; count=0; ovf=0.
- Reset mid-frame discards partial sums and any held result.
- State ACCUM:
  - in_ready=1; accept = in_valid & in_ready.
  - On accept: acc += sign-extended product (both components); cnt++.
  - Close condition: (accept & cnt==LEN-1) | (flush & (cnt!=0 | accept)).
  - On close: next-acc value is reduced and registered into sumreal/sumimag; count = number of products in the frame; ovf set; out_valid=1 on the next cycle; state -> HOLD.
  - On the same edge as close: acc and cnt clear.
- flush with cnt==0 and no accept is ignored (no empty frames).
- flush together with an accept: the sample is included, then the frame closes.
- State HOLD:
  - in_ready=0.
  - Outputs remain stable until out_ready=1.
  - On out_valid & out_ready: out_valid=0 next cycle; state -> ACCUM.
  - flush in HOLD is ignored.
- Latency: result valid 1 cycle after the final accepted product. Minimum 1 bubble cycle between frames (HOLD).
- Reduction:
  - ovf=1 if either component is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Without the optional feature, the result is the low OUT_W bits (two's-complement wrap).
- Arithmetic: signed throughout; the accumulator never overflows given the ACC_W rule.
- The upstream multiplier has no stall; it must only pulse in_valid while in_ready=1. A product presented with in_ready=0 is not captured.

Optional Feature:
- Macro: COMPLEX_ACCUM_SAT_EN.
- Defined: each component saturates to the OUT_W signed min/max on overflow; ovf is still reported.
- Undefined: wrap (truncate to low OUT_W bits); ovf still reported.

Decomposition:
- Package complex_accum_pkg:
  - FRAC default.
  - State encoding (ACCUM, HOLD).
  - Function for the OUT_W range check.
- Sub-module cplx_reduce:
  - Range check, plus saturate or wrap of one ACC_W component to OUT_W.
  - Instantiated twice (real, imag); the macro is evaluated only here.

Test Plan:
- Four products 39+26j (raw 1248, 832), LEN=4 -> one cycle after the 4th accept: out_valid=1, sumreal=4992 (156.0), sumimag=3328 (104.0), count=4, ovf=0.
- Four products 500+0j (raw 16000):
  - With SAT_EN: sumreal=16383, ovf=1.
  - Without: sumreal=-1536 (-48.0), ovf=1.
  - Four products -512-512j with SAT_EN: both components = -16384, ovf=1.
- Two products 1+1j (raw 32, 32), then flush alone -> sumreal=sumimag=64, count=2. flush with cnt=0 -> no out_valid. flush together with the 3rd product 1+0j -> sum 96+64 raw, count=3.
- Backpressure: frame completes, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs frozen, no capture. out_ready=1 -> out_valid drops next cycle; next frame starts from acc=0.
- Reset: two products accepted, reset pulsed low asynchronously -> all outputs 0 immediately. A following full frame of four 1+0j gives sumreal=128, count=4.
